spi_cmd_parser: RTL and testbench



---
 rtl/spi_cmd_parser.sv | 116 +++++++++++
 tb/tb_spi_cmd_parser.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_parser.sv
// Frames SPI receiver bytes with slave-select, decodes write-burst commands and
// issues single-cycle register writes; malformed frames are dropped and counted.
module spi_cmd_parser #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_ss,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  frame_active,
  output logic [7:0]            err_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    DISCARD = 3'd4
  } state_t;

  state_t                state_r;
  logic                  ss_meta_r;
  logic                  ss_sync_r;
  logic                  ss_prev_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [7:0]            hi_r;
  logic                  frame_start_s;
  logic                  frame_end_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    if (cnt == 8'hFF) begin
      return cnt;
    end else begin
      return cnt + 8'd1;
    end
  endfunction

  assign frame_start_s = ss_prev_r & ~ss_sync_r;
  assign frame_end_s   = ~ss_prev_r & ss_sync_r;

  // Slave-select synchroniser plus edge history; frame_active tracks ~ss_sync exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_meta_r    <= 1'b1;
      ss_sync_r    <= 1'b1;
      ss_prev_r    <= 1'b1;
      frame_active <= 1'b0;
    end else begin
      ss_meta_r    <= spi_ss;
      ss_sync_r    <= ss_meta_r;
      ss_prev_r    <= ss_sync_r;
      frame_active <= ~ss_meta_r;
    end
  end

  // Command/data FSM; frame end wins over a coincident byte strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      addr_r    <= '0;
      hi_r      <= 8'h00;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 16'h0000;
      err_count <= 8'h00;
    end else begin
      wr_en <= 1'b0;
      if (frame_end_s) begin
        if (state_r == DATA_LO) begin
          err_count <= sat_inc(err_count);
        end
        state_r <= IDLE;
      end else if (frame_start_s) begin
        state_r <= CMD;
      end else if (byte_valid) begin
        case (state_r)
          CMD: begin
            case (byte_in[7:6])
              2'b10: begin
                addr_r  <= byte_in[ADDR_WIDTH-1:0];
                state_r <= DATA_HI;
              end
              2'b00: begin
                state_r <= DISCARD;
              end
              default: begin
                err_count <= sat_inc(err_count);
                state_r   <= DISCARD;
              end
            endcase
          end
          DATA_HI: begin
            hi_r    <= byte_in;
            state_r <= DATA_LO;
          end
          DATA_LO: begin
            wr_en   <= 1'b1;
            wr_addr <= addr_r;
            wr_data <= {hi_r, byte_in};
            addr_r  <= addr_r + ADDR_WIDTH'(1);
            state_r <= DATA_HI;
          end
          default: begin
            state_r <= state_r;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Randomised and directed bench for spi_cmd_parser with a frame-level reference model.
module tb_spi_cmd_parser;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          spi_ss = 1'b1;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          frame_active;
  logic [7:0]    err_count;

  spi_cmd_parser #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .spi_ss(spi_ss), .byte_in(byte_in),
    .byte_valid(byte_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_active(frame_active), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            err_exp = 0;
  wr_t           exp_q[$];
  wr_t           head;
  logic [AW-1:0] obs_addr[$];
  logic [15:0]   obs_data[$];
  logic [7:0]    fb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle: any write must match the next expected write at its exact cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        n_checks++;
        obs_addr.push_back(wr_addr);
        obs_data.push_back(wr_data);
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: got addr=0x%0h data=0x%0h at cyc %0d, expected no write",
                   wr_addr, wr_data, cyc);
        end else begin
          head = exp_q.pop_front();
          if (head.cyc != cyc || head.addr != wr_addr || head.data != wr_data) begin
            n_fail++;
            $display("FAIL wr_match: got cyc=%0d addr=0x%0h data=0x%0h, expected cyc=%0d addr=0x%0h data=0x%0h",
                     cyc, wr_addr, wr_data, head.cyc, head.addr, head.data);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        n_checks++;
        n_fail++;
        head = exp_q.pop_front();
        $display("FAIL wr_missing: got no write at cyc %0d, expected addr=0x%0h data=0x%0h",
                 cyc, head.addr, head.data);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int stamp);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    stamp      = cyc;
  endtask

  // Drives one frame of fb and derives expected writes and error from the byte list.
  task automatic run_frame(input int maxgap);
    int         n;
    int         st;
    int         e;
    logic [1:0] opc;
    int         base;
    wr_t        w;
    n    = fb.size();
    opc  = 2'b00;
    base = 0;
    if (n > 0) begin
      opc  = fb[0][7:6];
      base = int'(fb[0]) % (1 << AW);
    end
    spi_ss = 1'b0;
    tick(4);
    check("frame_active_in", int'(frame_active), 1);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && maxgap > 0) tick($urandom_range(0, maxgap));
      send_byte(fb[i], st);
      if (opc == 2'b10 && i >= 2 && (i % 2) == 0) begin
        w.cyc  = st;
        w.addr = AW'((base + (i - 2) / 2) % (1 << AW));
        w.data = {fb[i-1], fb[i]};
        exp_q.push_back(w);
      end
    end
    spi_ss = 1'b1;
    tick(5);
    e = 0;
    if (n > 0) begin
      if (opc == 2'b01 || opc == 2'b11) e = 1;
      else if (opc == 2'b10 && ((n - 1) % 2) == 1) e = 1;
    end
    err_exp = (err_exp + e > 255) ? 255 : err_exp + e;
    check("err_count", int'(err_count), err_exp);
    check("pending_writes", exp_q.size(), 0);
    check("frame_active_out", int'(frame_active), 0);
  endtask

  initial begin
    int nobs;
    int st;
    int len;
    tick(2);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_frame_active", int'(frame_active), 0);
    rst_n = 1'b1;
    tick(3);

    // Single write
    nobs = obs_addr.size();
    fb = {8'h83, 8'h12, 8'h34};
    run_frame(0);
    check("single_count", obs_addr.size() - nobs, 1);
    check("single_addr", int'(obs_addr[nobs]), 3);
    check("single_data", int'(obs_data[nobs]), 16'h1234);
    check("single_err", int'(err_count), 0);
    check("hold_addr", int'(wr_addr), 3);
    check("hold_data", int'(wr_data), 16'h1234);

    // Burst with address wrap
    nobs = obs_addr.size();
    fb = {8'h8F, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame(0);
    check("wrap_count", obs_addr.size() - nobs, 2);
    check("wrap_addr0", int'(obs_addr[nobs]), 15);
    check("wrap_data0", int'(obs_data[nobs]), 16'hAABB);
    check("wrap_addr1", int'(obs_addr[nobs+1]), 0);
    check("wrap_data1", int'(obs_data[nobs+1]), 16'hCCDD);

    // Partial word, then a clean frame
    nobs = obs_addr.size();
    fb = {8'h81, 8'h55};
    run_frame(1);
    check("partial_err", int'(err_count), 1);
    check("partial_nowrite", obs_addr.size() - nobs, 0);
    fb = {8'h82, 8'h00, 8'h01};
    run_frame(1);
    check("after_partial_addr", int'(obs_addr[nobs]), 2);
    check("after_partial_data", int'(obs_data[nobs]), 16'h0001);
    check("after_partial_err", int'(err_count), 1);

    // Invalid, nop and empty frames
    fb = {8'hC0, 8'h11, 8'h22};
    run_frame(0);
    check("invalid_err", int'(err_count), 2);
    fb = {8'h00, 8'h11, 8'h22};
    run_frame(0);
    check("nop_err", int'(err_count), 2);
    fb = {};
    run_frame(0);
    check("empty_err", int'(err_count), 2);
    check("no_extra_writes", obs_addr.size() - nobs, 1);

    // Random frames, including back-to-back bytes
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(0, 7);
      fb = {};
      for (int i = 0; i < len; i++) fb.push_back(8'($urandom_range(0, 255)));
      run_frame($urandom_range(0, 2));
    end

    // Saturation
    for (int f = 0; f < 260; f++) begin
      fb = {8'($urandom_range(0, 63)) | 8'h40};
      run_frame(0);
    end
    check("sat_err", int'(err_count), 255);

    // Stray bytes outside a frame
    for (int i = 0; i < 10; i++) begin
      send_byte(8'($urandom_range(0, 255)) | 8'h80, st);
    end
    tick(3);
    check("stray_err", int'(err_count), 255);

    // Reset mid-frame
    spi_ss = 1'b0;
    tick(4);
    send_byte(8'h84, st);
    send_byte(8'h12, st);
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en", int'(wr_en), 0);
    check("midrst_wr_addr", int'(wr_addr), 0);
    check("midrst_wr_data", int'(wr_data), 0);
    check("midrst_err", int'(err_count), 0);
    check("midrst_frame_active", int'(frame_active), 0);
    err_exp = 0;
    spi_ss = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    nobs = obs_addr.size();
    fb = {8'h85, 8'hBE, 8'hEF};
    run_frame(0);
    check("post_rst_count", obs_addr.size() - nobs, 1);
    check("post_rst_addr", int'(obs_addr[nobs]), 5);
    check("post_rst_data", int'(obs_data[nobs]), 16'hBEEF);
    check("post_rst_err", int'(err_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
